// File: rtl/udl_count_pkg.sv
// Shared types and constants for the udl_count up/down/load counter.
// The operation enum is the contract between the decoder and the datapath.
package udl_count_pkg;

  localparam int unsigned UDL_COUNT_DEFAULT_WIDTH = 10;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_LOAD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

endpackage : udl_count_pkg

// File: rtl/udl_count_ctrl.sv
// Request decoder for udl_count: turns load/up/down into one operation.
// Load dominates; conflicting up+down collapses to hold.
module udl_count_ctrl
  import udl_count_pkg::*;
(
  input  logic    load_i,
  input  logic    up_i,
  input  logic    down_i,
  output cnt_op_e op_o
);

  always_comb begin
    op_o = CNT_HOLD;
    if (load_i) begin
      op_o = CNT_LOAD;
    end else if (up_i && !down_i) begin
      op_o = CNT_INC;
    end else if (down_i && !up_i) begin
      op_o = CNT_DEC;
    end
  end

endmodule : udl_count_ctrl

// File: rtl/udl_count.sv
// Parameterized up/down/load counter, modulo 2^WIDTH, async active-low clear.
// Output comes straight from the count register; no input-to-output path.
module udl_count
  import udl_count_pkg::*;
#(
  parameter int unsigned WIDTH = UDL_COUNT_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  if (WIDTH < 1 || WIDTH > 32) begin : gen_width_check
    $error("udl_count: WIDTH must be within 1..32");
  end

  cnt_op_e          cntOp;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  udl_count_ctrl u_ctrl (
    .load_i (load),
    .up_i   (up),
    .down_i (down),
    .op_o   (cntOp)
  );

  // Wraparound comes for free from the fixed-width add/subtract.
  always_comb begin
    count_d = count_q;
    unique case (cntOp)
      CNT_LOAD: count_d = in;
      CNT_INC:  count_d = count_q + WIDTH'(1);
      CNT_DEC:  count_d = count_q - WIDTH'(1);
      default:  count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out = count_q;

  // Simulation-only checks; synthesis ignores the assertion constructs.
  realtime lastEdgeT;

  always @(posedge clk or negedge rst) begin
    lastEdgeT <= $realtime;
  end

  always @(count_q) begin
    if ($realtime > 0) begin
      assert ($realtime == lastEdgeT);
    end
  end

  assert property (@(posedge clk) !rst |-> count_q == '0);

  assert property (@(posedge clk) disable iff (!rst)
                   cntOp == CNT_LOAD |=> count_q == $past(in));

endmodule : udl_count

// File: tb/tb_udl_count.sv
// Directed self-checking bench for udl_count (WIDTH = 10, 10 ns clock).
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_udl_count;

  localparam int W = 10;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         up   = 1'b0;
  logic         down = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] in   = '0;
  logic [W-1:0] out;

  int checkCount = 0;
  int failCount  = 0;

  udl_count #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .up   (up),
    .down (down),
    .load (load),
    .in   (in),
    .out  (out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: out=%0d (0x%03h), expected %0d (0x%03h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic u, input logic d,
                               input logic [W-1:0] val);
    load = ld;
    up   = u;
    down = d;
    in   = val;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held low from t=1 to t=113, sampled at every falling edge.
    #1 rst = 1'b0;
    #1 checkOutput("reset_assert", out, 10'd0);
    repeat (11) begin
      @(negedge clk);
      checkOutput("reset_hold", out, 10'd0);
    end
    #3 rst = 1'b1;
    checkOutput("reset_release", out, 10'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    for (int k = 1; k <= 29; k++) begin
      tick();
      checkOutput("sustained_up", out, W'(k));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    repeat (2) begin
      tick();
      checkOutput("hold_after_up", out, 10'h01D);
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 10'd1023);
    tick();
    checkOutput("load_max", out, 10'd1023);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd77);
    tick();
    checkOutput("wrap_up", out, 10'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
    tick();
    checkOutput("load_zero", out, 10'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'd500);
    tick();
    checkOutput("wrap_down", out, 10'd1023);

    applyStimulus(1'b1, 1'b1, 1'b0, 10'h155);
    tick();
    checkOutput("load_over_up", out, 10'h155);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h0AA);
    repeat (3) begin
      tick();
      checkOutput("up_down_hold", out, 10'h155);
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 10'd5);
    tick();
    checkOutput("mixed_load", out, 10'd5);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'd0);
    tick();
    checkOutput("mixed_down1", out, 10'd4);
    tick();
    checkOutput("mixed_down2", out, 10'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd0);
    tick();
    checkOutput("mixed_up", out, 10'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'd9);
    #3 in = 10'd300;
    tick();
    checkOutput("mixed_hold", out, 10'd4);

    // Count up to 17, then pulse reset for 3 ns between edges.
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd15);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 10'd0);
    tick();
    checkOutput("pre_reset_16", out, 10'd16);
    tick();
    checkOutput("pre_reset_17", out, 10'd17);
    #2 rst = 1'b0;
    #1 checkOutput("mid_reset_clear", out, 10'd0);
    #2 rst = 1'b1;
    #1 checkOutput("mid_reset_release", out, 10'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput("resume_up", out, W'(k));
    end

    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule : tb_udl_count
